seq_loader: RTL and testbench

- Host-side writer for the beam-config sequencer's load/play interface.
- Accepts framed bytes from the host byte stream (valid/ready) and drives the sequencer's write protocol (wr, seq_en, dato) to fill the programmable table with up to 31 entries.
- Optionally issues the playback start (seq_en pulse with mode) and tracks the 31-step run so the host knows when the sequencer is busy.

---
 rtl/seq_loader_pkg.sv | 31 +++
 rtl/seq_loader_if.sv | 22 ++
 rtl/seq_gap_timer.sv | 31 +++
 rtl/seq_loader.sv | 164 ++++++++++++++++
 tb/tb_seq_loader.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_loader_pkg.sv
// Shared types and constants for the beam-config sequencer loader.
package seq_loader_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR      = 3'd1,
    ARM      = 3'd2,
    DATA     = 3'd3,
    PLAY_ARM = 3'd4,
    RUN      = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         MAX_WORDS     = 31;
  localparam int         CNT_W         = $clog2(MAX_WORDS + 1);

  localparam logic [1:0] MODE_DEF  = 2'b00;
  localparam logic [1:0] MODE_T1   = 2'b01;
  localparam logic [1:0] MODE_T2   = 2'b10;
  localparam logic [1:0] MODE_PROG = 2'b11;

  localparam int HDR_PLAY_BIT = 7;
  localparam int HDR_MODE_MSB = 6;
  localparam int HDR_MODE_LSB = 5;
  localparam int HDR_CNT_MSB  = 4;

  function automatic logic [CNT_W-1:0] hdr_count(input logic [7:0] hdr);
    return hdr[HDR_CNT_MSB:0];
  endfunction

endpackage

// File: rtl/seq_loader_if.sv
// Host byte stream plus sequencer load/play signals.
interface seq_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       wr;
  logic       seq_en;
  logic [7:0] dato;
  logic [1:0] mode;
  logic       busy;
  logic       frame_err;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr, seq_en, dato, mode, busy, frame_err
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr, seq_en, dato, mode, busy, frame_err
  );
endinterface

// File: rtl/seq_gap_timer.sv
// Inter-byte gap down-counter; expired is asserted in the last idle cycle
// so the abort is registered exactly TIMEOUT_CYC cycles after the last byte.
module seq_gap_timer #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = W'(TIMEOUT_CYC - 1);
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  assign expired = en & ~clr & (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seq_loader.sv
// Host-to-sequencer table loader: turns framed host bytes into sequencer
// write cycles and optionally launches and tracks a playback run.
//
// state    | meaning
// IDLE     | hunting for SYNC_BYTE, other bytes consumed
// HDR      | waiting for the header byte
// ARM      | write-pointer reset cycle (wr=1, seq_en=1)
// DATA     | one sequencer write per accepted byte
// PLAY_ARM | last write on the bus, start pulse follows
// RUN      | playback in progress, mode held
module seq_loader
  import seq_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned PLAY_LEN    = 31,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_loader_if.slave bus
);
  localparam int RUN_W = $clog2(PLAY_LEN + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             play_q, play_d;
  logic [1:0]       pmode_q, pmode_d;
  logic             wr_q, wr_d;
  logic             seq_en_q, seq_en_d;
  logic [7:0]       dato_q, dato_d;
  logic [1:0]       mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             ferr_q, ferr_d;
  logic             in_ready, accept, tmr_en, tmr_clr, tmr_exp;

  assign in_ready = (state_q == IDLE) || (state_q == HDR) || (state_q == DATA);
  assign accept   = bus.in_valid & in_ready;
  assign tmr_en   = (state_q == HDR) || (state_q == DATA);
  assign tmr_clr  = accept | ~tmr_en;

  seq_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    play_d   = play_q;
    pmode_d  = pmode_q;
    wr_d     = 1'b0;
    seq_en_d = 1'b0;
    dato_d   = dato_q;
    mode_d   = MODE_DEF;
    busy_d   = busy_q;
    ferr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept && bus.in_data == SYNC_BYTE) state_d = HDR;
      end
      HDR: begin
        if (tmr_exp) begin
          ferr_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (accept) begin
          play_d  = bus.in_data[HDR_PLAY_BIT];
          pmode_d = bus.in_data[HDR_MODE_MSB:HDR_MODE_LSB];
          cnt_d   = hdr_count(bus.in_data);
          busy_d  = 1'b1;
          if (hdr_count(bus.in_data) != '0) begin
            wr_d     = 1'b1;
            seq_en_d = 1'b1;
            state_d  = ARM;
          end else if (bus.in_data[HDR_PLAY_BIT]) begin
            state_d = PLAY_ARM;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      ARM: state_d = DATA;
      DATA: begin
        if (tmr_exp) begin
          ferr_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (accept) begin
          wr_d   = 1'b1;
          dato_d = bus.in_data;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (play_q) begin
              state_d = PLAY_ARM;
            end else begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
      PLAY_ARM: begin
        seq_en_d = 1'b1;
        mode_d   = pmode_q;
        run_d    = RUN_W'(PLAY_LEN);
        state_d  = RUN;
      end
      RUN: begin
        // The start-pulse cycle is followed by PLAY_LEN steps with mode held.
        if (run_q == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          mode_d = pmode_q;
          run_d  = run_q - RUN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      run_q    <= '0;
      play_q   <= 1'b0;
      pmode_q  <= MODE_DEF;
      wr_q     <= 1'b0;
      seq_en_q <= 1'b0;
      dato_q   <= '0;
      mode_q   <= MODE_DEF;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      play_q   <= play_d;
      pmode_q  <= pmode_d;
      wr_q     <= wr_d;
      seq_en_q <= seq_en_d;
      dato_q   <= dato_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      ferr_q   <= ferr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.wr        = wr_q;
  assign bus.seq_en    = seq_en_q;
  assign bus.dato      = dato_q;
  assign bus.mode      = mode_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_seq_loader.sv
// Directed bench for seq_loader: frame vectors with hand-computed event
// counts, plus cycle-exact sequences for timing, timeout and reset.
module tb_seq_loader;
  logic clk;
  logic rst_n;

  seq_loader_if ifc ();

  seq_loader #(.TIMEOUT_CYC(16), .PLAY_LEN(31), .SYNC_BYTE(8'hA5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         ngarb;
    logic [7:0] hdr;
    int         ndata;
    logic [7:0] base;
    logic [7:0] step;
    int         gap;
    int         e_arm;
    int         e_wr;
    int         e_st;
    int         e_mode;
    int         e_run;
    int         e_fe;
    int         e_busy;
  } vec_t;

  vec_t vecs [9];

  int n_pass = 0;
  int n_total = 0;
  int gap_nr;
  bit mon_on = 1'b0;
  int arm_n, wr_n, st_n, st_mode, pre_mode_n, run_n, fe_n, busy_seen;
  logic [7:0] dq [$];

  task automatic chk(input string nm, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (ifc.wr && ifc.seq_en) arm_n++;
      if (ifc.wr && !ifc.seq_en) begin
        wr_n++;
        dq.push_back(ifc.dato);
      end
      if (ifc.seq_en && !ifc.wr) begin
        st_n++;
        st_mode = int'(ifc.mode);
      end
      if (ifc.mode != 2'b00) begin
        if (st_n == 0) pre_mode_n++;
        else run_n++;
      end
      if (ifc.frame_err) fe_n++;
      if (ifc.busy) busy_seen = 1;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    ifc.in_data = b;
    ifc.in_valid = 1'b1;
    @(negedge clk);
    while (!ifc.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ifc.in_ready) begin
      n_total++;
      $display("FAIL ready_wait: in_ready still %0d after %0d cycles, required 1", ifc.in_ready, t);
    end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      if (!ifc.in_ready) gap_nr++;
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_wr"}, int'(ifc.wr), 0);
    chk({tag, "_seq_en"}, int'(ifc.seq_en), 0);
    chk({tag, "_dato"}, int'(ifc.dato), 0);
    chk({tag, "_mode"}, int'(ifc.mode), 0);
    chk({tag, "_busy"}, int'(ifc.busy), 0);
    chk({tag, "_frame_err"}, int'(ifc.frame_err), 0);
    chk({tag, "_in_ready"}, int'(ifc.in_ready), 1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int mism;
    logic [7:0] d;
    string p;
    p = $sformatf("v%0d", idx);
    arm_n = 0; wr_n = 0; st_n = 0; st_mode = 0; pre_mode_n = 0;
    run_n = 0; fe_n = 0; busy_seen = 0; gap_nr = 0;
    dq.delete();
    mon_on = 1'b1;
    for (int i = 0; i < v.ngarb; i++) send_byte((i % 2 == 1) ? 8'hFF : 8'h00, 0);
    send_byte(8'hA5, 0);
    send_byte(v.hdr, 0);
    for (int i = 0; i < v.ndata; i++) begin
      d = v.base + 8'(i) * v.step;
      send_byte(d, v.gap);
    end
    repeat (50) @(posedge clk);
    #1;
    mon_on = 1'b0;
    chk({p, "_arm"}, arm_n, v.e_arm);
    chk({p, "_wr_pulses"}, wr_n, v.e_wr);
    chk({p, "_start_pulses"}, st_n, v.e_st);
    chk({p, "_start_mode"}, st_mode, v.e_mode);
    chk({p, "_run_mode_cycles"}, run_n, v.e_run);
    chk({p, "_mode_during_load"}, pre_mode_n, 0);
    chk({p, "_frame_err"}, fe_n, v.e_fe);
    chk({p, "_busy_seen"}, busy_seen, v.e_busy);
    chk({p, "_busy_end"}, int'(ifc.busy), 0);
    chk({p, "_ready_end"}, int'(ifc.in_ready), 1);
    mism = 0;
    for (int i = 0; i < dq.size(); i++) begin
      d = v.base + 8'(i) * v.step;
      if (dq[i] != d) mism++;
    end
    chk({p, "_dato_mismatches"}, mism, 0);
    if (v.gap > 0) chk({p, "_ready_in_gaps_low"}, gap_nr, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    int k;
    //             garb hdr    nd  base   step  gap arm wr  st mode run fe busy
    vecs[0] = '{0, 8'hE3, 3,  8'h11, 8'h11, 0, 1, 3,  1, 3, 32, 0, 1};
    vecs[1] = '{2, 8'h01, 1,  8'h5A, 8'h00, 0, 1, 1,  0, 0, 0,  0, 1};
    vecs[2] = '{0, 8'h1F, 31, 8'h01, 8'h01, 0, 1, 31, 0, 0, 0,  0, 1};
    vecs[3] = '{0, 8'h00, 0,  8'h00, 8'h00, 0, 0, 0,  0, 0, 0,  0, 0};
    vecs[4] = '{0, 8'hC0, 0,  8'h00, 8'h00, 0, 0, 0,  1, 2, 32, 0, 1};
    vecs[5] = '{0, 8'h43, 3,  8'h40, 8'h03, 2, 1, 3,  0, 0, 0,  0, 1};
    vecs[6] = '{0, 8'h85, 2,  8'h70, 8'h01, 0, 1, 2,  0, 0, 0,  1, 1};
    vecs[7] = '{0, 8'hE3, 3,  8'h0A, 8'h05, 0, 1, 3,  1, 3, 32, 0, 1};
    vecs[8] = '{0, 8'hBF, 31, 8'h80, 8'h01, 0, 1, 31, 1, 1, 32, 0, 1};

    rst_n = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data = 8'h00;
    do_reset();
    chk_cleared("reset");

    // Cycle-exact basic load and play: A5 E3 11 22 33 held on the bus.
    @(posedge clk); #1;
    ifc.in_valid = 1'b1; ifc.in_data = 8'hA5;
    @(posedge clk); #1;
    ifc.in_data = 8'hE3;
    @(posedge clk); #1;
    chk("arm_wr", int'(ifc.wr), 1);
    chk("arm_seq_en", int'(ifc.seq_en), 1);
    chk("arm_in_ready", int'(ifc.in_ready), 0);
    chk("arm_busy", int'(ifc.busy), 1);
    chk("arm_mode", int'(ifc.mode), 0);
    ifc.in_data = 8'h11;
    @(posedge clk); #1;
    chk("data0_wr", int'(ifc.wr), 0);
    chk("data0_seq_en", int'(ifc.seq_en), 0);
    chk("data0_in_ready", int'(ifc.in_ready), 1);
    @(posedge clk); #1;
    chk("w1_wr", int'(ifc.wr), 1);
    chk("w1_seq_en", int'(ifc.seq_en), 0);
    chk("w1_dato", int'(ifc.dato), 'h11);
    ifc.in_data = 8'h22;
    @(posedge clk); #1;
    chk("w2_wr", int'(ifc.wr), 1);
    chk("w2_dato", int'(ifc.dato), 'h22);
    ifc.in_data = 8'h33;
    @(posedge clk); #1;
    chk("w3_wr", int'(ifc.wr), 1);
    chk("w3_dato", int'(ifc.dato), 'h33);
    chk("w3_in_ready", int'(ifc.in_ready), 0);
    chk("w3_mode", int'(ifc.mode), 0);
    ifc.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("start_wr", int'(ifc.wr), 0);
    chk("start_seq_en", int'(ifc.seq_en), 1);
    chk("start_mode", int'(ifc.mode), 3);
    chk("start_busy", int'(ifc.busy), 1);
    bad = 0;
    for (int i = 0; i < 31; i++) begin
      @(posedge clk); #1;
      if (ifc.seq_en || ifc.wr || ifc.mode != 2'b11 || !ifc.busy) bad++;
    end
    chk("run_hold_bad_cycles", bad, 0);
    @(posedge clk); #1;
    chk("run_end_mode", int'(ifc.mode), 0);
    chk("run_end_busy", int'(ifc.busy), 0);
    chk("run_end_in_ready", int'(ifc.in_ready), 1);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Timeout distance: frame_err must appear 16 edges after the last accept.
    send_byte(8'hA5, 0);
    send_byte(8'h85, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ifc.frame_err) begin
        k = i;
        break;
      end
    end
    chk("timeout_latency", k, 16);
    chk("timeout_busy", int'(ifc.busy), 0);
    chk("timeout_seq_en", int'(ifc.seq_en), 0);
    @(posedge clk); #1;
    chk("timeout_pulse_width", int'(ifc.frame_err), 0);
    chk("timeout_in_ready", int'(ifc.in_ready), 1);

    // Reset in the middle of DATA.
    send_byte(8'hA5, 0);
    send_byte(8'hE3, 0);
    send_byte(8'h11, 0);
    chk("pre_rst_data_wr", int'(ifc.wr), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_cleared("rst_data");
    run_vec(9, vecs[0]);

    // Reset in the middle of RUN.
    send_byte(8'hA5, 0);
    send_byte(8'hC0, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_run_mode", int'(ifc.mode), 2);
    chk("pre_rst_run_busy", int'(ifc.busy), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_cleared("rst_run");
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ifc.mode != 2'b00 || ifc.busy || ifc.seq_en || ifc.wr) bad++;
    end
    chk("rst_run_quiet_cycles", bad, 0);
    run_vec(10, vecs[4]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
